// File: rtl/build_write_data_pkg.sv
// Shared widths for the pixel-to-word packer feeding the DDR write path.
package build_write_data_pkg;

    localparam int PIXEL_W      = 16;
    localparam int WORD_W       = 128;
    localparam int PIX_PER_WORD = WORD_W / PIXEL_W;
    localparam int CNT_W        = $clog2(PIX_PER_WORD);

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [CNT_W-1:0]   count_t;

endpackage

// File: rtl/build_write_data.sv
// Packs eight 16-bit pixels into one 128-bit word, first pixel in the low bits,
// and flags words that begin a frame on tuser_out.
module build_write_data
    import build_write_data_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic [PIXEL_W-1:0] data_in,
    input  logic               newframe_in,
    output logic               valid_out,
    input  logic               ready_out,
    output logic [WORD_W-1:0]  data_out,
    output logic               tuser_out
);

    localparam count_t LAST_SLOT = count_t'(PIX_PER_WORD - 1);

    logic [PIX_PER_WORD-2:0][PIXEL_W-1:0] slot_q, slot_d;
    count_t count_q, count_d;
    logic   acc_tuser_q, acc_tuser_d;
    word_t  data_out_q, data_out_d;
    logic   tuser_out_q, tuser_out_d;
    logic   valid_out_q, valid_out_d;
    logic   in_fire;
    logic   out_fire;

    assign ready_in  = !valid_out_q || ready_out;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign tuser_out = tuser_out_q;

    assign in_fire  = valid_in && ready_in;
    assign out_fire = valid_out_q && ready_out;

    // A frame start wins over completing a word: the stale partial is simply
    // abandoned by restarting the count, so its slots never reach the output.
    always_comb begin
        slot_d      = slot_q;
        count_d     = count_q;
        acc_tuser_d = acc_tuser_q;
        data_out_d  = data_out_q;
        tuser_out_d = tuser_out_q;
        valid_out_d = valid_out_q;

        if (out_fire) begin
            valid_out_d = 1'b0;
        end

        if (in_fire) begin
            if (newframe_in) begin
                slot_d[0]   = data_in;
                count_d     = count_t'(1);
                acc_tuser_d = 1'b1;
            end else if (count_q == LAST_SLOT) begin
                data_out_d  = {data_in, slot_q};
                tuser_out_d = acc_tuser_q;
                valid_out_d = 1'b1;
                count_d     = '0;
                acc_tuser_d = 1'b0;
            end else begin
                slot_d[count_q] = data_in;
                count_d         = count_q + count_t'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_q      <= '0;
            count_q     <= '0;
            acc_tuser_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            count_q     <= count_d;
            acc_tuser_q <= acc_tuser_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_out_q  <= '0;
            tuser_out_q <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            tuser_out_q <= tuser_out_d;
            valid_out_q <= valid_out_d;
        end
    end

endmodule

// File: tb/tb_build_write_data.sv
// Directed bench for build_write_data: frame start, backpressure, streaming,
// mid-word frame restart and asynchronous reset.
module tb_build_write_data;

    logic         clk_in;
    logic         rst_in;
    logic         valid_in;
    logic         ready_in;
    logic [15:0]  data_in;
    logic         newframe_in;
    logic         valid_out;
    logic         ready_out;
    logic [127:0] data_out;
    logic         tuser_out;

    int checks;
    int passes;

    build_write_data dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_in     (data_in),
        .newframe_in (newframe_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .tuser_out   (tuser_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Present one pixel for exactly one rising edge, then withdraw it.
    task automatic send_pix(input logic [15:0] d, input logic nf);
        @(negedge clk_in);
        valid_in    = 1'b1;
        data_in     = d;
        newframe_in = nf;
        @(posedge clk_in);
        #1;
        valid_in    = 1'b0;
        newframe_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in      = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        newframe_in = 1'b0;
        ready_out   = 1'b0;
        #3;
        checks++;
        if (ready_in !== 1'b1) $display("[TB] FAIL reset_ready_in got=%b exp=1", ready_in);
        else passes++;
        checks++;
        if (valid_out !== 1'b0) $display("[TB] FAIL reset_valid_out got=%b exp=0", valid_out);
        else passes++;
        checks++;
        if (data_out !== 128'h0) $display("[TB] FAIL reset_data_out got=%h exp=0", data_out);
        else passes++;
        checks++;
        if (tuser_out !== 1'b0) $display("[TB] FAIL reset_tuser_out got=%b exp=0", tuser_out);
        else passes++;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_frame_start();
        logic [127:0] exp_word;
        exp_word  = 128'hBEEF_DEAD_3210_7654_5678_1234_DCBA_ABCD;
        ready_out = 1'b1;
        send_pix(16'hABCD, 1'b1); idle(2);
        send_pix(16'hDCBA, 1'b0); idle(2);
        send_pix(16'h1234, 1'b0); idle(2);
        send_pix(16'h5678, 1'b0); idle(2);
        send_pix(16'h7654, 1'b0); idle(2);
        send_pix(16'h3210, 1'b0); idle(2);
        send_pix(16'hDEAD, 1'b0); idle(2);
        checks++;
        if (valid_out !== 1'b0) $display("[TB] FAIL frame_early_valid got=%b exp=0", valid_out);
        else passes++;
        send_pix(16'hBEEF, 1'b0);
        checks++;
        if (valid_out !== 1'b1) $display("[TB] FAIL frame_valid got=%b exp=1", valid_out);
        else passes++;
        checks++;
        if (data_out !== exp_word) $display("[TB] FAIL frame_data got=%h exp=%h", data_out, exp_word);
        else passes++;
        checks++;
        if (tuser_out !== 1'b1) $display("[TB] FAIL frame_tuser got=%b exp=1", tuser_out);
        else passes++;
        @(posedge clk_in);
        #1;
        checks++;
        if (valid_out !== 1'b0) $display("[TB] FAIL frame_valid_clear got=%b exp=0", valid_out);
        else passes++;
        checks++;
        if (data_out !== exp_word) $display("[TB] FAIL frame_data_hold got=%h exp=%h", data_out, exp_word);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_word;
        logic [127:0] exp_next;
        exp_word  = 128'hBEEF_DEAD_3210_7654_5678_1234_DCBA_ABCD;
        exp_next  = {16'h0007, 16'h0006, 16'h0005, 16'h0004,
                     16'h0003, 16'h0002, 16'h0001, 16'hEEEE};
        ready_out = 1'b1;
        send_pix(16'hABCD, 1'b1);
        send_pix(16'hDCBA, 1'b0);
        send_pix(16'h1234, 1'b0);
        send_pix(16'h5678, 1'b0);
        send_pix(16'h7654, 1'b0);
        send_pix(16'h3210, 1'b0);
        send_pix(16'hDEAD, 1'b0);
        @(negedge clk_in);
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 16'hBEEF;
        @(posedge clk_in);
        #1;
        data_in = 16'hFFFF;
        checks++;
        if (valid_out !== 1'b1) $display("[TB] FAIL bp_valid got=%b exp=1", valid_out);
        else passes++;
        checks++;
        if (ready_in !== 1'b0) $display("[TB] FAIL bp_ready_in got=%b exp=0", ready_in);
        else passes++;
        repeat (2) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (data_out !== exp_word) $display("[TB] FAIL bp_hold_data got=%h exp=%h", data_out, exp_word);
            else passes++;
            checks++;
            if (tuser_out !== 1'b1 || valid_out !== 1'b1)
                $display("[TB] FAIL bp_hold_flags got=%b%b exp=11", tuser_out, valid_out);
            else passes++;
        end
        @(negedge clk_in);
        ready_out = 1'b1;
        data_in   = 16'hEEEE;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) $display("[TB] FAIL bp_release_valid got=%b exp=0", valid_out);
        else passes++;
        for (int k = 1; k <= 7; k++) send_pix(16'(k), 1'b0);
        checks++;
        if (data_out !== exp_next || valid_out !== 1'b1)
            $display("[TB] FAIL bp_next_word got=%h v=%b exp=%h v=1", data_out, valid_out, exp_next);
        else passes++;
        checks++;
        if (tuser_out !== 1'b0) $display("[TB] FAIL bp_next_tuser got=%b exp=0", tuser_out);
        else passes++;
    endtask

    task automatic test_streaming();
        logic [127:0] exp_word;
        int words;
        exp_word  = {8{16'h4444}};
        words     = 0;
        ready_out = 1'b1;
        @(negedge clk_in);
        valid_in    = 1'b1;
        data_in     = 16'h4444;
        newframe_in = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (ready_in !== 1'b1) $display("[TB] FAIL stream_ready_in cycle=%0d got=%b exp=1", i, ready_in);
            else passes++;
            checks++;
            if (valid_out !== (i % 8 == 0))
                $display("[TB] FAIL stream_valid cycle=%0d got=%b exp=%b", i, valid_out, (i % 8 == 0));
            else passes++;
            if (i % 8 == 0) begin
                words++;
                checks++;
                if (data_out !== exp_word || tuser_out !== 1'b0)
                    $display("[TB] FAIL stream_word cycle=%0d got=%h u=%b exp=%h u=0", i, data_out, tuser_out, exp_word);
                else passes++;
            end
        end
        valid_in = 1'b0;
        checks++;
        if (words !== 3) $display("[TB] FAIL stream_word_count got=%0d exp=3", words);
        else passes++;
        idle(1);
    endtask

    task automatic test_midword_newframe();
        logic [127:0] exp_word;
        exp_word  = {16'h6007, 16'h6006, 16'h6005, 16'h6004,
                     16'h6003, 16'h6002, 16'h6001, 16'h5555};
        ready_out = 1'b1;
        repeat (3) send_pix(16'h4444, 1'b0);
        send_pix(16'h5555, 1'b1);
        for (int k = 1; k <= 6; k++) send_pix(16'h6000 + 16'(k), 1'b0);
        checks++;
        if (valid_out !== 1'b0) $display("[TB] FAIL nf_early_valid got=%b exp=0", valid_out);
        else passes++;
        send_pix(16'h6007, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp_word)
            $display("[TB] FAIL nf_word got=%h v=%b exp=%h v=1", data_out, valid_out, exp_word);
        else passes++;
        checks++;
        if (tuser_out !== 1'b1) $display("[TB] FAIL nf_tuser got=%b exp=1", tuser_out);
        else passes++;
    endtask

    task automatic test_async_reset();
        logic [127:0] exp_word;
        exp_word  = {16'h8008, 16'h8007, 16'h8006, 16'h8005,
                     16'h8004, 16'h8003, 16'h8002, 16'h8001};
        ready_out = 1'b1;
        for (int k = 1; k <= 5; k++) send_pix(16'h7000 + 16'(k), 1'b0);
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        checks++;
        if (data_out !== 128'h0 || valid_out !== 1'b0 || tuser_out !== 1'b0)
            $display("[TB] FAIL areset_outputs got=%h v=%b u=%b exp=0", data_out, valid_out, tuser_out);
        else passes++;
        checks++;
        if (ready_in !== 1'b1) $display("[TB] FAIL areset_ready_in got=%b exp=1", ready_in);
        else passes++;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 1; k <= 3; k++) send_pix(16'h8000 + 16'(k), 1'b0);
        checks++;
        if (valid_out !== 1'b0) $display("[TB] FAIL areset_stale_word got=%b exp=0", valid_out);
        else passes++;
        for (int k = 4; k <= 8; k++) send_pix(16'h8000 + 16'(k), 1'b0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp_word || tuser_out !== 1'b0)
            $display("[TB] FAIL areset_word got=%h v=%b u=%b exp=%h v=1 u=0", data_out, valid_out, tuser_out, exp_word);
        else passes++;
        @(posedge clk_in);
        #1;
        checks++;
        if (valid_out !== 1'b0) $display("[TB] FAIL areset_single_word got=%b exp=0", valid_out);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_frame_start();
        test_backpressure();
        test_streaming();
        test_midword_newframe();
        test_async_reset();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
